// File: rtl/reg_file_bist.sv
// Register-file BIST initiator: write/read-back of P0/P1 (plus walking 1/0 when BIST_WALK_EN is defined).
// All outputs registered; busy lasts NPAT*2*2^ADDR_WIDTH cycles; start is ignored unless idle.
module reg_file_bist #(
    parameter int          DATA_WIDTH = 32,
    parameter int          ADDR_WIDTH = 5,
    parameter logic [15:0] SIG        = 16'hA5A5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic                  wen,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic [ADDR_WIDTH-1:0] raddr1,
    output logic [ADDR_WIDTH-1:0] raddr2,
    input  logic [DATA_WIDTH-1:0] rdata1,
    input  logic [DATA_WIDTH-1:0] rdata2,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [8:0]            fail_cnt,
    output logic [ADDR_WIDTH-1:0] first_fail_addr,
    output logic                  first_fail_port
);

`ifdef BIST_WALK_EN
    localparam int PW = 2;
`else
    localparam int PW = 1;
`endif
    localparam logic [DATA_WIDTH-1:0] ONE = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, WR, RD, DONE} state_t;

    state_t                st;
    logic [ADDR_WIDTH-1:0] a;
    logic [PW-1:0]         pat;

    // Odd pattern indices are the bitwise complement of the preceding even one.
    function automatic logic [DATA_WIDTH-1:0] pgen(input logic [PW-1:0] p, input logic [ADDR_WIDTH-1:0] x);
        logic [DATA_WIDTH-1:0] v;
        v = '0;
        v[DATA_WIDTH-1 -: 16] = SIG;
        v[ADDR_WIDTH-1:0] = x;
`ifdef BIST_WALK_EN
        if (p[1]) v = ONE << x;
`endif
        if (p[0]) v = ~v;
        return v;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] expv(input logic [PW-1:0] p, input logic [ADDR_WIDTH-1:0] x);
        return (x == '0) ? '0 : pgen(p, x);
    endfunction

    logic [ADDR_WIDTH-1:0] a_inv, a_nxt;
    logic [PW-1:0]         pat_nxt;
    logic                  m1, m2, last_a, last_pat;
    logic [9:0]            cnt_sum;
    logic [8:0]            cnt_nxt;

    assign a_inv    = ~a;
    assign a_nxt    = a + 1'b1;
    assign pat_nxt  = pat + 1'b1;
    assign last_a   = &a;
    assign last_pat = &pat;
    assign m1       = (st == RD) && (rdata1 != expv(pat, a));
    assign m2       = (st == RD) && (rdata2 != expv(pat, a_inv));
    assign cnt_sum  = {1'b0, fail_cnt} + {9'd0, m1} + {9'd0, m2};
    assign cnt_nxt  = cnt_sum[9] ? 9'h1FF : cnt_sum[8:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st              <= IDLE;
            a               <= '0;
            pat             <= '0;
            waddr           <= '0;
            wen             <= 1'b0;
            wdata           <= '0;
            raddr1          <= '0;
            raddr2          <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            fail_cnt        <= '0;
            first_fail_addr <= '0;
            first_fail_port <= 1'b0;
        end else begin
            case (st)
                IDLE: begin
                    if (start) begin
                        done            <= 1'b0;
                        pass            <= 1'b0;
                        fail_cnt        <= '0;
                        first_fail_addr <= '0;
                        first_fail_port <= 1'b0;
                        pat             <= '0;
                        a               <= '0;
                        st              <= WR;
                        busy            <= 1'b1;
                        wen             <= 1'b1;
                        waddr           <= '0;
                        wdata           <= pgen('0, '0);
                    end
                end
                WR: begin
                    if (last_a) begin
                        a      <= '0;
                        st     <= RD;
                        wen    <= 1'b0;
                        raddr1 <= '0;
                        raddr2 <= '1;
                    end else begin
                        a     <= a_nxt;
                        waddr <= a_nxt;
                        wdata <= pgen(pat, a_nxt);
                    end
                end
                RD: begin
                    fail_cnt <= cnt_nxt;
                    // Port 1 wins a same-cycle tie for the first-failure record.
                    if ((m1 || m2) && fail_cnt == '0) begin
                        first_fail_addr <= a;
                        first_fail_port <= !m1;
                    end
                    if (last_a) begin
                        a <= '0;
                        if (!last_pat) begin
                            pat   <= pat_nxt;
                            st    <= WR;
                            wen   <= 1'b1;
                            waddr <= '0;
                            wdata <= pgen(pat_nxt, '0);
                        end else begin
                            st   <= DONE;
                            busy <= 1'b0;
                            done <= 1'b1;
                            pass <= (cnt_nxt == '0);
                        end
                    end else begin
                        a      <= a_nxt;
                        raddr1 <= a_nxt;
                        raddr2 <= ~a_nxt;
                    end
                end
                default: begin
                    st <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_file_bist.sv
// Bench for reg_file_bist: behavioural register file with injectable faults plus a pass/address model.
module tb_reg_file_bist;
    localparam int DW = 32;
    localparam int AW = 5;
`ifdef BIST_WALK_EN
    localparam int NPAT = 4;
`else
    localparam int NPAT = 2;
`endif
    localparam int RUNLEN = NPAT * 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] waddr, raddr1, raddr2, first_fail_addr;
    logic          wen, busy, done, pass, first_fail_port;
    logic [DW-1:0] wdata, rdata1, rdata2;
    logic [8:0]    fail_cnt;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    reg_file_bist dut (
        .clk(clk), .rst(rst), .start(start),
        .waddr(waddr), .wen(wen), .wdata(wdata),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1), .rdata2(rdata2),
        .busy(busy), .done(done), .pass(pass), .fail_cnt(fail_cnt),
        .first_fail_addr(first_fail_addr), .first_fail_port(first_fail_port)
    );

    // Fault kinds: 0 none, 1 register f_addr reads 0 during pass f_pass, 2 stuck-1, 3 stuck-0 on port f_port bit f_bit.
    logic [DW-1:0] rf [0:31];
    int bcyc = 0;
    int f_kind = 0, f_addr = 0, f_pass = 0, f_port = 0, f_bit = 0;

    always @(posedge clk) begin
        if (wen) rf[waddr] <= wdata;
        bcyc <= busy ? bcyc + 1 : 0;
    end

    always_comb begin
        rdata1 = (raddr1 == '0) ? '0 : rf[raddr1];
        rdata2 = (raddr2 == '0) ? '0 : rf[raddr2];
        if (f_kind == 1 && busy && (bcyc / 64) == f_pass) begin
            if (int'(raddr1) == f_addr) rdata1 = '0;
            if (int'(raddr2) == f_addr) rdata2 = '0;
        end
        if (f_kind == 2) begin
            if (f_port == 0) rdata1[f_bit] = 1'b1; else rdata2[f_bit] = 1'b1;
        end
        if (f_kind == 3) begin
            if (f_port == 0) rdata1[f_bit] = 1'b0; else rdata2[f_bit] = 1'b0;
        end
    end

    function automatic logic [31:0] pat_val(int p, int x);
        logic [31:0] base;
        base = 32'hA5A5_0000 + x;
        case (p)
            0:       return base;
            1:       return ~base;
            2:       return 32'd1 << x;
            default: return ~(32'd1 << x);
        endcase
    endfunction

    // Walks every pass/address/port in test order and predicts what a correct BIST reports.
    task automatic model(output int cnt, output int faddr, output int fport);
        bit got = 0;
        cnt = 0; faddr = 0; fport = 0;
        for (int p = 0; p < NPAT; p++)
            for (int ad = 0; ad < 32; ad++)
                for (int port = 0; port < 2; port++) begin
                    int r;
                    logic [31:0] ev, ov;
                    r  = (port == 0) ? ad : 31 - ad;
                    ev = (r == 0) ? 32'd0 : pat_val(p, r);
                    ov = ev;
                    if (f_kind == 1 && r == f_addr && p == f_pass) ov = 32'd0;
                    if (f_kind == 2 && port == f_port) ov[f_bit] = 1'b1;
                    if (f_kind == 3 && port == f_port) ov[f_bit] = 1'b0;
                    if (ov != ev) begin
                        if (cnt < 511) cnt++;
                        if (!got) begin got = 1; faddr = ad; fport = port; end
                    end
                end
    endtask

    task automatic do_run(input int snap_idx, input int mid_start, output int blen,
                          output logic [31:0] s_wdata, output logic s_wen, output logic s_done,
                          output int wcyc);
        s_wdata = '0; s_wen = 1'b0; s_done = 1'b0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        wcyc = 0;
        while (!busy && wcyc < 8) begin @(negedge clk); wcyc++; end
        blen = 0;
        while (busy && blen < 1000) begin
            start = (blen == mid_start);
            if (blen == snap_idx) begin s_wdata = wdata; s_wen = wen; s_done = done; end
            @(negedge clk);
            blen++;
        end
        start = 1'b0;
        checks++;
        if (wcyc >= 8 || blen >= 1000) begin
            failures++;
            $display("FAIL run_timeout wait=%0d len=%0d", wcyc, blen);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, wen, pass} !== 4'b0)
            begin failures++; $display("FAIL reset_ctrl busy/done/wen/pass=%b want 0000", {busy, done, wen, pass}); end
        checks++;
        if (fail_cnt !== 9'd0 || first_fail_addr !== '0 || first_fail_port !== 1'b0)
            begin failures++; $display("FAIL reset_status cnt=%0d addr=%0d port=%0d want 0", fail_cnt, first_fail_addr, first_fail_port); end
        checks++;
        if (waddr !== '0 || raddr1 !== '0 || raddr2 !== '0 || wdata !== '0)
            begin failures++; $display("FAIL reset_addr waddr=%0d r1=%0d r2=%0d wdata=%h want 0", waddr, raddr1, raddr2, wdata); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_good();
        int blen, wc; logic [31:0] sw; logic se, sd;
        f_kind = 0;
        do_run(5, -1, blen, sw, se, sd, wc);
        checks++; if (wc !== 0) begin failures++; $display("FAIL good_busy_rise delay=%0d want 0", wc); end
        checks++; if (sw !== 32'hA5A50005 || se !== 1'b1)
            begin failures++; $display("FAIL good_wr5 wdata=%h wen=%b want a5a50005 1", sw, se); end
        checks++; if (blen !== RUNLEN) begin failures++; $display("FAIL good_len got %0d want %0d", blen, RUNLEN); end
        checks++; if (done !== 1'b1 || pass !== 1'b1 || fail_cnt !== 9'd0)
            begin failures++; $display("FAIL good_result done=%b pass=%b cnt=%0d want 1 1 0", done, pass, fail_cnt); end
    endtask

    task automatic test_kill7();
        int blen, wc; logic [31:0] sw; logic se, sd;
        f_kind = 1; f_addr = 7; f_pass = 0;
        do_run(-1, -1, blen, sw, se, sd, wc);
        checks++; if (fail_cnt !== 9'd2 || first_fail_addr !== 5'd7 || first_fail_port !== 1'b0)
            begin failures++; $display("FAIL kill7 cnt=%0d addr=%0d port=%0d want 2 7 0", fail_cnt, first_fail_addr, first_fail_port); end
        checks++; if (done !== 1'b1 || pass !== 1'b0)
            begin failures++; $display("FAIL kill7_pass done=%b pass=%b want 1 0", done, pass); end
        f_kind = 0;
    endtask

    task automatic test_start_ignored();
        int blen, wc; logic [31:0] sw; logic se, sd;
        f_kind = 0;
        do_run(-1, 40, blen, sw, se, sd, wc);
        checks++; if (blen !== RUNLEN || pass !== 1'b1)
            begin failures++; $display("FAIL mid_start len=%0d pass=%b want %0d 1", blen, pass, RUNLEN); end
    endtask

    task automatic test_rst_mid();
        int n, blen, wc; logic [31:0] sw; logic se, sd;
        f_kind = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        n = 0;
        while (busy && n < 70) begin @(negedge clk); n++; end
        rst = 1'b1;
        #1;
        checks++; if (wen !== 1'b0 || busy !== 1'b0 || done !== 1'b0)
            begin failures++; $display("FAIL rst_mid wen=%b busy=%b done=%b (cyc %0d) want 0 0 0", wen, busy, done, n); end
        @(negedge clk); rst = 1'b0;
        do_run(-1, -1, blen, sw, se, sd, wc);
        checks++; if (blen !== RUNLEN || pass !== 1'b1 || done !== 1'b1)
            begin failures++; $display("FAIL rst_rerun len=%0d pass=%b done=%b want %0d 1 1", blen, pass, done, RUNLEN); end
    endtask

    task automatic test_stuck31();
        int blen, wc, mc, ma, mp; logic [31:0] sw; logic se, sd;
        f_kind = 2; f_port = 1; f_bit = 31;
        model(mc, ma, mp);
        do_run(-1, -1, blen, sw, se, sd, wc);
        checks++; if (int'(fail_cnt) !== mc || int'(first_fail_addr) !== ma || int'(first_fail_port) !== mp)
            begin failures++; $display("FAIL stuck31 cnt=%0d addr=%0d port=%0d want %0d %0d %0d", fail_cnt, first_fail_addr, first_fail_port, mc, ma, mp); end
        checks++; if (pass !== 1'b0) begin failures++; $display("FAIL stuck31_pass got %b want 0", pass); end
        f_kind = 0;
    endtask

    task automatic test_random();
        int blen, wc, mc, ma, mp; logic [31:0] sw; logic se, sd;
        for (int i = 0; i < 6; i++) begin
            f_kind = $urandom_range(0, 3);
            f_addr = $urandom_range(0, 31);
            f_pass = $urandom_range(0, NPAT - 1);
            f_port = $urandom_range(0, 1);
            f_bit  = $urandom_range(0, 31);
            model(mc, ma, mp);
            do_run(-1, -1, blen, sw, se, sd, wc);
            checks++; if (int'(fail_cnt) !== mc || pass !== (mc == 0) || blen !== RUNLEN)
                begin failures++; $display("FAIL rand%0d kind=%0d cnt=%0d pass=%b len=%0d want %0d %b %0d", i, f_kind, fail_cnt, pass, blen, mc, mc == 0, RUNLEN); end
            if (mc > 0) begin
                checks++; if (int'(first_fail_addr) !== ma || int'(first_fail_port) !== mp)
                    begin failures++; $display("FAIL rand%0d_first addr=%0d port=%0d want %0d %0d", i, first_fail_addr, first_fail_port, ma, mp); end
            end
        end
        f_kind = 0;
    endtask

    task automatic test_back_to_back();
        int blen, wc; logic [31:0] sw; logic se, sd;
        f_kind = 0;
        do_run(-1, -1, blen, sw, se, sd, wc);
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0 || done !== 1'b1 || pass !== 1'b1)
            begin failures++; $display("FAIL done_start busy=%b done=%b pass=%b want 0 1 1", busy, done, pass); end
        do_run(0, -1, blen, sw, se, sd, wc);
        checks++; if (sd !== 1'b0) begin failures++; $display("FAIL done_clear got %b want 0", sd); end
        checks++; if (blen !== RUNLEN || pass !== 1'b1)
            begin failures++; $display("FAIL b2b_run len=%0d pass=%b want %0d 1", blen, pass, RUNLEN); end
    endtask

`ifdef BIST_WALK_EN
    task automatic test_walk();
        int blen, wc; logic [31:0] sw; logic se, sd;
        f_kind = 0;
        do_run(131, -1, blen, sw, se, sd, wc);
        checks++; if (sw !== 32'h00000008 || se !== 1'b1)
            begin failures++; $display("FAIL walk_wr3 wdata=%h wen=%b want 00000008 1", sw, se); end
        checks++; if (blen !== 256 || pass !== 1'b1)
            begin failures++; $display("FAIL walk_run len=%0d pass=%b want 256 1", blen, pass); end
    endtask
`endif

    initial begin
        rst = 1'b1;
        start = 1'b0;
        test_reset();
        test_good();
        test_kill7();
        test_start_ignored();
        test_rst_mid();
        test_stuck31();
        test_random();
        test_back_to_back();
`ifdef BIST_WALK_EN
        test_walk();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reg_file_bist.md
Name: reg_file_bist

Overview:
- Built-in self-test initiator for the 32x32 register file. Drives the write port (waddr/wen/wdata) and both read ports (raddr1/raddr2), and checks rdata1/rdata2 against expected patterns.
- Sits beside reg_file and takes ownership of its ports while busy; the integrator muxes in the datapath when idle.
- Reports pass/fail, the mismatch count and the first failing location.

Parameters:
- DATA_WIDTH, 32, register width; must be >= 16+ADDR_WIDTH.
- ADDR_WIDTH, 5, register address width; depth = 2^ADDR_WIDTH.
- SIG, 16'hA5A5, signature placed in the upper 16 bits of pattern P0.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to run the test; ignored while busy.
- waddr  out  ADDR_WIDTH  write address to reg_file.
- wen  out  1  write enable to reg_file.
- wdata  out  DATA_WIDTH  write data to reg_file.
- raddr1  out  ADDR_WIDTH  read address, port 1.
- raddr2  out  ADDR_WIDTH  read address, port 2.
- rdata1  in  DATA_WIDTH  combinational read data, port 1.
- rdata2  in  DATA_WIDTH  combinational read data, port 2.
- busy  out  1  test in progress.
- done  out  1  sticky; test finished, cleared by the next accepted start.
- pass  out  1  done && fail_cnt==0.
- fail_cnt  out  9  total mismatches, saturating at 511.
- first_fail_addr  out  ADDR_WIDTH  address of the first mismatch.
- first_fail_port  out  1  0 = port 1, 1 = port 2, for the first mismatch.

Behaviour:
- Reset (async, any state): FSM=IDLE; a=0; pat=0. Outputs waddr, raddr1, raddr2, wdata = 0; wen, busy, done = 0; fail_cnt=0; first_fail_* = 0.
- All outputs are registered. Address counter a is ADDR_WIDTH bits; patterns are indexed by pat.
- Patterns:
  - P0(a) = {SIG, zeros, a}.
  - P1(a) = ~P0(a).
- Expected value: E(x) = 0 when x==0, else Ppat(x). reg_file hardwires register 0 to zero; writes to address 0 are still issued.
- States:
  - IDLE: wen=0, busy=0. When start is high: clear done, fail_cnt and first_fail_*; set pat=0, a=0; go to WR.
  - WR: busy=1, wen=1, waddr=a, wdata=Ppat(a). Increment a each cycle; after a==2^ADDR_WIDTH-1, a wraps to 0 and the FSM goes to RD.
  - RD: wen=0, raddr1=a, raddr2=~a. In each RD cycle, compare rdata1 vs E(a) and rdata2 vs E(~a) at the closing edge.
    - Each mismatching port adds 1 to fail_cnt; two mismatches in the same cycle add 2.
    - The first mismatch ever latches first_fail_addr/first_fail_port. If both ports fail in that cycle, latch port 0 with addr a.
    - After the last address: if pat < last pattern, increment pat, set a=0, go to WR; else go to DONE.
  - DONE: busy=0, done=1, wen=0; go to IDLE the next cycle. done and the fail status stay held until the next start.
- Timing: busy rises the cycle after start and stays high for exactly 128 cycles (2 patterns x (32 WR + 32 RD)).
- start while busy: no effect.
- start asserted in the same cycle DONE transitions to IDLE: not accepted; it is sampled in IDLE only.
- rst mid-run: wen drops immediately (async), no partial result is reported, and done=0.
- fail_cnt saturates at 511 and never wraps.

Optional Feature:
- BIST_WALK_EN defined: two extra patterns follow P1.
  - P2(a) = 1 << a (walking one).
  - P3(a) = ~(1 << a) (walking zero).
  - Requires DATA_WIDTH >= 2^ADDR_WIDTH. busy lasts 256 cycles.
- Not defined: only P0 and P1 run; busy lasts 128 cycles; P2/P3 logic is absent.

Test Plan:
- Good reg_file, pulse start -> busy high for 128 cycles; done=1; pass=1; fail_cnt=0. In the WR cycle with a=5 of pass 0: wdata=32'hA5A50005, wen=1.
- Force rf[7] to 32'h0 before the pass-0 RD phase -> port 1 at a=7 and port 2 at a=24 both mismatch. fail_cnt=2, first_fail_addr=7 (lower a, checked first), first_fail_port=0, pass=0.
- Pulse start again mid-run at cycle 40 -> ignored; busy still ends at cycle 128.
- Assert rst at busy cycle 70 -> wen=0, busy=0, done=0 immediately. A new start then gives a full 128-cycle run with pass=1.
- Stuck-at-1 fault on rdata2 bit 31 -> every port-2 read with ~a != 0 whose expected bit 31 is 0 fails.
  - P0 has bit 31 = 1 and P1 has bit 31 = 0, so pass-1 port-2 compares fail for ~a != 0: 31 fails.
  - Port-2 read of address 0 expects 0, so it fails in both passes: 2 fails.
  - Total fail_cnt=33; first_fail_addr=31 (pass 0, a=31 reads address 0), first_fail_port=1.
- With BIST_WALK_EN defined, good reg_file -> busy for 256 cycles; in the pass-2 WR cycle with a=3, wdata=32'h00000008; pass=1.
